// File: rtl/system_cpu_0_mult_seq.sv
// ---------------------------------------------------------------------------
// system_cpu_0_mult_seq
//
// Iterative multiplier for the CPU M-stage. Each BUSY cycle multiplies one
// CHUNK-bit slice of src2 by the full src1 and adds the result into a
// 2*WIDTH-bit accumulator. The slices are processed least-significant first.
// The block supports the low-word multiply (MUL) and three high-word modes:
// signed x signed, signed x unsigned and unsigned x unsigned.
//
// Parameters:
//   WIDTH  operand width in bits; must be a multiple of CHUNK
//   CHUNK  width of the src2 slice processed per cycle (N = WIDTH/CHUNK >= 1)
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   reset       synchronous, active-high; aborts any operation in flight
//   in_valid    operands and op are valid
//   in_ready    block can accept operands (high only in IDLE)
//   in_op       00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   in_src1     multiplicand (signed in SS/SU)
//   in_src2     multiplier (signed in SS only)
//   out_valid   result valid; held until out_ready
//   out_ready   consumer accepts the result
//   out_result  selected product word
//   busy        FSM is not IDLE
//
// Optional build macro:
//   SYSTEM_CPU_0_MULT_EARLY_OUT_EN  finish as soon as every src2 bit above
//                                   the current slice is zero and src2 is not
//                                   a signed-negative multiplier. The result
//                                   is bit-identical to a full run.
// ---------------------------------------------------------------------------
module system_cpu_0_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = WIDTH + CHUNK + 2;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SS  = 2'b01;
    localparam logic [1:0] OP_SU  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     src1_q, src2_q;
    logic [1:0]           op_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 last_slice;
    logic                 finish;

    // One slice product, already shifted into place. src1 is extended by one
    // bit (sign or zero) and the slice likewise, so a single signed multiply
    // covers every mode; only the top slice can be negative, and only in SS.
    // Everything is reduced mod 2^(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] partial_product(
        input logic [WIDTH-1:0] s1,
        input logic [WIDTH-1:0] s2,
        input logic [1:0]       op,
        input logic [CW-1:0]    idx
    );
        logic [CHUNK-1:0]          slice;
        logic signed [WIDTH:0]     a;
        logic signed [CHUNK:0]     b;
        logic signed [PW-1:0]      p;
        logic signed [2*WIDTH+1:0] wide;
        slice = CHUNK'(s2 >> (int'(idx) * CHUNK));
        a     = {(op == OP_SS || op == OP_SU) & s1[WIDTH-1], s1};
        b     = {(op == OP_SS && int'(idx) == N - 1) & slice[CHUNK-1], slice};
        p     = a * b;
        wide  = (2*WIDTH+2)'(p);
        wide  = wide <<< (int'(idx) * CHUNK);
        return wide[2*WIDTH-1:0];
    endfunction

`ifdef SYSTEM_CPU_0_MULT_EARLY_OUT_EN
    // True when no src2 bit above slice idx is set.
    function automatic logic upper_zero(
        input logic [WIDTH-1:0] s2,
        input logic [CW-1:0]    idx
    );
        return (s2 >> ((int'(idx) + 1) * CHUNK)) == '0;
    endfunction
`endif

    assign last_slice = (int'(cnt) == N - 1);

`ifdef SYSTEM_CPU_0_MULT_EARLY_OUT_EN
    // A negative SS multiplier always has its top bit set, so the explicit
    // sign test only documents why such an op can never stop early.
    assign finish = last_slice ||
                    (upper_zero(src2_q, cnt) && !(op_q == OP_SS && src2_q[WIDTH-1]));
`else
    assign finish = last_slice;
`endif

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next state and outputs ----
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        out_result = (op_q == OP_MUL) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- operand latch and accumulate ----
    always_ff @(posedge clk) begin
        if (reset) begin
            src1_q <= '0;
            src2_q <= '0;
            op_q   <= OP_MUL;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            src1_q <= in_src1;
            src2_q <= in_src2;
            op_q   <= in_op;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc <= acc + partial_product(src1_q, src2_q, op_q, cnt);
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_system_cpu_0_mult_seq.sv
module tb_system_cpu_0_mult_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 16;
    localparam int N     = WIDTH / CHUNK;
`ifdef SYSTEM_CPU_0_MULT_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_src1 = 32'd0;
    logic [31:0] in_src2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;

    always #5 clk = ~clk;

    system_cpu_0_mult_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference product by plain 64-bit arithmetic.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{(op == 2'd1 || op == 2'd2) & a[31]}}, a};
        eb = {{32{(op == 2'd1) & b[31]}}, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from accept to visible result.
    function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
        int k;
        if (!EARLY || (op == 2'd1 && b[31])) return N + 1;
        k = 0;
        for (int i = 0; i < N; i++)
            if (b[i*CHUNK +: CHUNK] != '0) k = i;
        return k + 2;
    endfunction

    // Abstract cycle model: idle / computing for L-1 cycles / holding result.
    typedef enum {M_IDLE, M_BUSY, M_VALID} mstate_t;
    mstate_t     m_state = M_IDLE;
    int          m_left = 0;
    logic [31:0] m_res = 32'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (in_valid) begin
                    m_res   = ref_mul(in_op, in_src1, in_src2);
                    m_left  = lat_of(in_op, in_src2) - 1;
                    m_state = M_BUSY;
                end
                M_BUSY: begin
                    m_left--;
                    if (m_left <= 0) m_state = M_VALID;
                end
                M_VALID: if (out_ready) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon in_ready", 32'(in_ready), 32'(m_state == M_IDLE));
            check("mon busy", 32'(busy), 32'(m_state != M_IDLE));
            check("mon out_valid", 32'(out_valid), 32'(m_state == M_VALID));
            if (m_state == M_VALID) check("mon out_result", out_result, m_res);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        out_ready = 1'b1;
        tick();
        // operands are only sampled on the accept edge
        in_valid = 1'b0;
        in_op    = 2'($urandom_range(3));
        in_src1  = $urandom;
        in_src2  = $urandom;
        wait_valid(lat);
        check({name, " latency"}, 32'(lat), 32'(lat_of(op, b)));
        check({name, " result"}, out_result, exp);
        tick();
        check({name, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        tick();
        mon_en = 1'b1;
        tick();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'd0);
        reset = 1'b0;
        tick();

        do_op(2'd0, 32'd7,        32'd6,        32'h0000002A, "mul_7x6");
        do_op(2'd1, 32'h80000000, 32'h80000000, 32'h40000000, "ss_min");
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "ss_m1");
        do_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "su_m1");
        do_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "uu_max");
        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_max");
        do_op(2'd0, 32'h00010000, 32'h00010000, 32'h00000000, "mul_2p32");
        do_op(2'd3, 32'h00010000, 32'h00010000, 32'h00000001, "uu_2p32");
        do_op(2'd2, 32'h00000002, 32'h80000000, 32'h00000001, "su_top");
        do_op(2'd1, 32'h00000002, 32'h80000000, 32'hFFFFFFFF, "ss_top");
        do_op(2'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, "ss_mix");
        do_op(2'd2, 32'h80000000, 32'h80000000, 32'hC0000000, "su_min");
        do_op(2'd0, 32'h12345678, 32'h00000005, 32'h5B05B058, "mul_small");
        do_op(2'd1, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, "ss_neg2");
        do_op(2'd0, 32'h12345678, 32'h00000000, 32'h00000000, "mul_src2_zero");

        // Backpressure with in_valid held high throughout.
        in_valid  = 1'b1;
        in_op     = 2'd3;
        in_src1   = 32'hFFFFFFFF;
        in_src2   = 32'hFFFFFFFF;
        out_ready = 1'b0;
        tick();
        in_op   = 2'd0;
        in_src1 = 32'd9;
        in_src2 = 32'd9;
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'(lat_of(2'd3, 32'hFFFFFFFF)));
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_result", out_result, 32'hFFFFFFFE);
            check("bp in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp idle in_ready", 32'(in_ready), 32'd1);
        check("bp idle out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp next latency", 32'(lat), 32'(lat_of(2'd0, 32'd9)));
        check("bp next result", out_result, 32'd81);
        tick();

        // Reset during BUSY aborts the op.
        in_valid = 1'b1;
        in_op    = 2'd3;
        in_src1  = 32'hFFFFFFFF;
        in_src2  = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy low", 32'(busy), 32'd0);
        tick();
        tick();
        check("abort no result", 32'(out_valid), 32'd0);
        do_op(2'd0, 32'd3, 32'd5, 32'd15, "mul_after_reset");

        // Reset wins over a simultaneous result handshake.
        in_valid  = 1'b1;
        in_op     = 2'd0;
        in_src1   = 32'd3;
        in_src2   = 32'd4;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("done_reset result", out_result, 32'd12);
        tick();
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        check("done_reset out_valid", 32'(out_valid), 32'd0);
        check("done_reset in_ready", 32'(in_ready), 32'd1);
        check("done_reset out_result", out_result, 32'd0);
        tick();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
